// File: rtl/arch_reg_read_responder_pkg.sv
// Shared CPU definitions for the debug-side architectural register read port.
`ifndef ARCH_REG_NUM_WIDTH
`define ARCH_REG_NUM_WIDTH 5
`endif
`ifndef ARCH_REG_NUM
`define ARCH_REG_NUM 32
`endif
`ifndef PHYS_REG_NUM_WIDTH
`define PHYS_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

package arch_reg_read_responder_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    READ   = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } arr_state_e;

  localparam int ARR_DEF_TMO_CYC = 16;

  // Width of a counter that must reach tmo-1; never narrower than one bit.
  function automatic int stall_cnt_w(input int tmo);
    return (tmo > 2) ? $clog2(tmo) : 1;
  endfunction

endpackage

// File: rtl/arch_reg_read_if.sv
// Request/response bundle between the debug front-end and the register read responder.
`ifndef ARCH_REG_NUM_WIDTH
`define ARCH_REG_NUM_WIDTH 5
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

interface ARCH_REG_READ_IF #(
  parameter int ARCH_W = `ARCH_REG_NUM_WIDTH,
  parameter int VAL_W  = `REG_VAL_WIDTH
);
  logic              rd_en;
  logic [ARCH_W-1:0] read_red_addr_req;
  logic              read_valid;
  logic [VAL_W-1:0]  read_value;

  modport slave (
    input  rd_en,
    input  read_red_addr_req,
    output read_valid,
    output read_value
  );

  modport master (
    output rd_en,
    output read_red_addr_req,
    input  read_valid,
    input  read_value
  );
endinterface

// File: rtl/arch_reg_read_responder.sv
// Reads a committed architectural register: RAT lookup, then PRF read with a bounded
// wait on prf_rd_ready; response held in RESP until the requester drops rd_en.
`ifndef ARCH_REG_NUM_WIDTH
`define ARCH_REG_NUM_WIDTH 5
`endif
`ifndef PHYS_REG_NUM_WIDTH
`define PHYS_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

module arch_reg_read_responder
  import arch_reg_read_responder_pkg::*;
#(
  parameter int ARCH_W  = `ARCH_REG_NUM_WIDTH,
  parameter int PHYS_W  = `PHYS_REG_NUM_WIDTH,
  parameter int VAL_W   = `REG_VAL_WIDTH,
  parameter int TMO_CYC = ARR_DEF_TMO_CYC
) (
  input  logic              clk,
  input  logic              reset,
  ARCH_REG_READ_IF.slave    ARCH_REG_READ_if,
  input  logic              quiesced,
  output logic [ARCH_W-1:0] rat_lookup_arch,
  input  logic [PHYS_W-1:0] rat_lookup_phys,
  output logic              prf_rd_en,
  output logic [PHYS_W-1:0] prf_rd_addr,
  input  logic              prf_rd_ready,
  input  logic [VAL_W-1:0]  prf_rd_data,
  output logic              rsp_timeout
);

  localparam int CNT_W = stall_cnt_w(TMO_CYC);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TMO_CYC - 1);

  arr_state_e        state_q;
  logic [ARCH_W-1:0] arch_q;
  logic [PHYS_W-1:0] tag_q;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  stall_d;
  logic              read_valid_q;
  logic [VAL_W-1:0]  read_value_q;
  logic              rsp_timeout_q;
  logic              prf_rd_en_q;

  logic              rd_en;
  logic [ARCH_W-1:0] req_addr;

  assign rd_en    = ARCH_REG_READ_if.rd_en;
  assign req_addr = ARCH_REG_READ_if.read_red_addr_req;
  assign stall_d  = stall_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      arch_q        <= '0;
      tag_q         <= '0;
      stall_q       <= '0;
      read_valid_q  <= 1'b0;
      read_value_q  <= '0;
      rsp_timeout_q <= 1'b0;
      prf_rd_en_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A request seen while the pipeline is still draining simply waits here.
          if (rd_en && quiesced) begin
            arch_q <= req_addr;
            if (req_addr == '0) begin
              read_value_q  <= '0;
              rsp_timeout_q <= 1'b0;
              read_valid_q  <= 1'b1;
              state_q       <= RESP;
            end else begin
              state_q <= LOOKUP;
            end
          end
        end

        LOOKUP: begin
          if (!rd_en) begin
            state_q <= IDLE;
          end else begin
            tag_q       <= rat_lookup_phys;
            stall_q     <= '0;
            prf_rd_en_q <= 1'b1;
            state_q     <= READ;
          end
        end

        READ: begin
          // Abort wins over ready, and ready wins over the timeout on the last cycle.
          if (!rd_en) begin
            prf_rd_en_q <= 1'b0;
            state_q     <= IDLE;
          end else if (prf_rd_ready) begin
            prf_rd_en_q <= 1'b0;
            state_q     <= WAIT;
          end else if (stall_q == STALL_LAST) begin
            prf_rd_en_q   <= 1'b0;
            read_value_q  <= '0;
            rsp_timeout_q <= 1'b1;
            read_valid_q  <= 1'b1;
            state_q       <= RESP;
          end else begin
            stall_q <= stall_d;
          end
        end

        WAIT: begin
          if (!rd_en) begin
            state_q <= IDLE;
          end else begin
            read_value_q  <= prf_rd_data;
            rsp_timeout_q <= 1'b0;
            read_valid_q  <= 1'b1;
            state_q       <= RESP;
          end
        end

        RESP: begin
          if (!rd_en) begin
            read_valid_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            state_q       <= IDLE;
          end
        end

        default: begin
          prf_rd_en_q  <= 1'b0;
          read_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign ARCH_REG_READ_if.read_valid = read_valid_q;
  assign ARCH_REG_READ_if.read_value = read_value_q;
  assign rat_lookup_arch             = arch_q;
  assign prf_rd_en                   = prf_rd_en_q;
  assign prf_rd_addr                 = tag_q;
  assign rsp_timeout                 = rsp_timeout_q;

endmodule
